// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int         BCD_MAX      = 9999;
  localparam int         BCD_DIGITS   = 4;
  localparam bcd_digit_t BCD_OVF_CODE = 4'hF;

endpackage

// File: rtl/bcd_add3.sv
// Combinational shift-and-add-3 digit corrector: digits >= 5 get +3 before the shift.
import bcd_pkg::*;

module bcd_add3 (
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per cycle, four digits (result is value mod 10000).
// Optional BCD_OVERFLOW_CLAMP_EN: values above 9999 set ovf and force all digits to 4'hF.
import bcd_pkg::*;

module bin_to_bcd_seq #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             listo,
  output bcd_digit_t       unidades,
  output bcd_digit_t       decenas,
  output bcd_digit_t       centenas,
  output bcd_digit_t       millares,
  output logic             ovf,
  output bcd_state_t       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: start is taken only in IDLE (busy=0); busy stays high through SHIFT and DONE,
  // and listo is a one-cycle pulse in the cycle the digit outputs change.

  bcd_state_t                   state, state_nxt;
  logic [WIDTH-1:0]             sr;
  logic [CW-1:0]                cnt;
  bcd_digit_t [BCD_DIGITS-1:0]  acc;
  bcd_digit_t [BCD_DIGITS-1:0]  acc_adj;
  logic [4*BCD_DIGITS-1:0]      adj_flat;
  logic                         last_bit;

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (acc[i]),
      .dout (acc_adj[i])
    );
  end

  assign adj_flat  = acc_adj;
  assign last_bit  = (cnt == CW'(WIDTH - 1));
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef BCD_OVERFLOW_CLAMP_EN
  logic ovf_flag;
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_flag <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (state == IDLE && start) ovf_flag <= (32'(bin) > 32'(BCD_MAX));
      if (state == DONE)          ovf_q    <= ovf_flag;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr       <= '0;
      cnt      <= '0;
      acc      <= '0;
      listo    <= 1'b0;
      unidades <= '0;
      decenas  <= '0;
      centenas <= '0;
      millares <= '0;
    end else begin
      listo <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr  <= bin;
            cnt <= '0;
            acc <= '0;
          end
        end
        SHIFT: begin
          // The top bit of the corrected thousands digit is a ten-thousands carry; dropping it gives mod 10000.
          acc <= {adj_flat[4*BCD_DIGITS-2:0], sr[WIDTH-1]};
          sr  <= sr << 1;
          cnt <= cnt + CW'(1);
        end
        DONE: begin
          listo <= 1'b1;
`ifdef BCD_OVERFLOW_CLAMP_EN
          if (ovf_flag) begin
            unidades <= BCD_OVF_CODE;
            decenas  <= BCD_OVF_CODE;
            centenas <= BCD_OVF_CODE;
            millares <= BCD_OVF_CODE;
          end else begin
            unidades <= acc[0];
            decenas  <= acc[1];
            centenas <= acc[2];
            millares <= acc[3];
          end
`else
          unidades <= acc[0];
          decenas  <= acc[1];
          centenas <= acc[2];
          millares <= acc[3];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (WIDTH=14) against an arithmetic decimal-digit model.
import bcd_pkg::*;

module tb_bin_to_bcd_seq;

  localparam int W = 14;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] bin;
  logic         busy;
  logic         listo;
  bcd_digit_t   unidades, decenas, centenas, millares;
  logic         ovf;
  bcd_state_t   dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];

  bin_to_bcd_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bin       (bin),
    .busy      (busy),
    .listo     (listo),
    .unidades  (unidades),
    .decenas   (decenas),
    .centenas  (centenas),
    .millares  (millares),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, millares, centenas, decenas, unidades} from plain decimal arithmetic.
  function automatic logic [16:0] model(input int v);
    int m;
`ifdef BCD_OVERFLOW_CLAMP_EN
    if (v > 9999) return {1'b1, 16'hFFFF};
`endif
    m = v % 10000;
    return {1'b0, 4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic [16:0] observed();
    return {ovf, millares, centenas, decenas, unidades};
  endfunction

  // driver: one conversion; returns listo latency (edges after acceptance), digits at listo,
  // and digits sampled mid-conversion
  task automatic run_conv(input int v, output int lat, output logic [16:0] obs,
                          output logic [16:0] mid);
    lat = -1; obs = '0; mid = '0;
    @(negedge clk);
    bin = W'(v); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bin = W'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 7) mid = observed();
      if (listo) begin
        lat = k; obs = observed();
        break;
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; bin = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_cmp++; if (observed() !== 17'h0) begin n_err++; $display("FAIL reset_digits got=%h exp=%h", observed(), 17'h0); end
    n_cmp++; if (listo !== 1'b0) begin n_err++; $display("FAIL reset_listo got=%b exp=0", listo); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
  endtask

  task automatic test_zero_and_1234();
    int lat; logic [16:0] obs, mid;
    run_conv(0, lat, obs, mid);
    n_cmp++; if (lat !== W + 1) begin n_err++; $display("FAIL zero_latency got=%0d exp=%0d", lat, W + 1); end
    n_cmp++; if (obs !== model(0)) begin n_err++; $display("FAIL zero_digits got=%h exp=%h", obs, model(0)); end
    run_conv(1234, lat, obs, mid);
    n_cmp++; if (lat !== W + 1) begin n_err++; $display("FAIL d1234_latency got=%0d exp=%0d", lat, W + 1); end
    n_cmp++; if (obs !== 17'h01234) begin n_err++; $display("FAIL d1234_digits got=%h exp=%h", obs, 17'h01234); end
    @(posedge clk); #1;
    n_cmp++; if (listo !== 1'b0) begin n_err++; $display("FAIL d1234_listo_width got=%b exp=0", listo); end
    repeat (5) @(posedge clk); #1;
    n_cmp++; if (observed() !== 17'h01234) begin n_err++; $display("FAIL d1234_hold got=%h exp=%h", observed(), 17'h01234); end
  endtask

  task automatic test_boundary();
    int vals[4] = '{9999, 10000, 12345, 16383};
    int lat; logic [16:0] obs, mid;
    foreach (vals[i]) begin
      run_conv(vals[i], lat, obs, mid);
      n_cmp++; if (obs !== model(vals[i])) begin n_err++; $display("FAIL boundary_%0d got=%h exp=%h", vals[i], obs, model(vals[i])); end
      n_cmp++; if (lat !== W + 1) begin n_err++; $display("FAIL boundary_lat_%0d got=%0d exp=%0d", vals[i], lat, W + 1); end
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0; int pulse_k = -1; int busy_bad = 0;
    logic [16:0] obs = '0;
    @(negedge clk); bin = W'(4321); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      if (k <= W && busy !== 1'b1) busy_bad++;
      if (listo) begin pulses++; pulse_k = k; obs = observed(); end
      if (k == 4) begin start = 1'b1; bin = W'(5678); end
      if (k == 5) begin start = 1'b0; bin = W'($urandom); end
    end
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL ignore_pulses got=%0d exp=1", pulses); end
    n_cmp++; if (pulse_k !== W + 1) begin n_err++; $display("FAIL ignore_latency got=%0d exp=%0d", pulse_k, W + 1); end
    n_cmp++; if (obs !== model(4321)) begin n_err++; $display("FAIL ignore_digits got=%h exp=%h", obs, model(4321)); end
    n_cmp++; if (busy_bad !== 0) begin n_err++; $display("FAIL ignore_busy low_cycles=%0d exp=0", busy_bad); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0; int lat; logic [16:0] obs, mid;
    @(negedge clk); bin = W'(7777); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1; rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_cmp++; if (observed() !== 17'h0) begin n_err++; $display("FAIL rstmid_digits got=%h exp=%h", observed(), 17'h0); end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (listo) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL rstmid_listo got=%0d exp=0", pulses); end
    run_conv(42, lat, obs, mid);
    n_cmp++; if (obs !== 17'h00042) begin n_err++; $display("FAIL rstmid_fresh got=%h exp=%h", obs, 17'h00042); end
  endtask

  task automatic test_back_to_back();
    int ks[$]; logic [16:0] ds[$];
    @(negedge clk); bin = W'(56); start = 1'b1;
    for (int k = 0; k <= 60; k++) begin
      @(posedge clk); #1;
      if (listo) begin ks.push_back(k); ds.push_back(observed()); end
      if (k == 39) start = 1'b0;
    end
    n_cmp++; if (ks.size() !== 3) begin n_err++; $display("FAIL b2b_pulses got=%0d exp=3", ks.size()); end
    foreach (ks[i]) begin
      n_cmp++; if (ks[i] !== (W + 1) + i * (W + 2)) begin n_err++; $display("FAIL b2b_when_%0d got=%0d exp=%0d", i, ks[i], (W + 1) + i * (W + 2)); end
      n_cmp++; if (ds[i] !== model(56)) begin n_err++; $display("FAIL b2b_digits_%0d got=%h exp=%h", i, ds[i], model(56)); end
    end
  endtask

  task automatic test_random();
    int v; int lat; logic [16:0] obs, mid, exp, prev;
    prev = model(56);
    for (int i = 0; i < 20; i++) begin
      v = (i % 3 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 16383));
      exp_q.push_back(model(v));
      run_conv(v, lat, obs, mid);
      exp = exp_q.pop_front();
      n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL random_%0d bin=%0d got=%h exp=%h", i, v, obs, exp); end
      n_cmp++; if (mid !== prev) begin n_err++; $display("FAIL random_hold_%0d got=%h exp=%h", i, mid, prev); end
      n_cmp++; if (lat !== W + 1) begin n_err++; $display("FAIL random_lat_%0d got=%0d exp=%0d", i, lat, W + 1); end
      prev = exp;
    end
  endtask

  initial begin
    test_reset();
    test_zero_and_1234();
    test_boundary();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
